gcd_driver: RTL and testbench
=============================

Name: gcd_driver

Overview:
Initiator for the team's 8-bit GCD engine, which uses a start/ready handshake. It buffers operand pairs from an upstream valid/ready stream in a small FIFO. It issues one pair at a time to the engine, captures the result, and presents operands plus GCD on a downstream valid/ready stream. Zero operands are resolved locally because the engine never terminates on them. A watchdog detects a hung engine.

Parameters:
DEPTH, 4, operand FIFO entries (power of two, ≥2)
TIMEOUT, 1024, max cycles an engine transaction may stay busy before fault

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  upstream pair valid
req_ready  out  1  FIFO not full
req_a  in  8  operand A
req_b  in  8  operand B
eng_start  out  1  start pulse to engine
eng_a  out  8  operand A to engine
eng_b  out  8  operand B to engine
eng_ready  in  1  engine idle/done (1=READY, 0=BUSY)
eng_out  in  8  engine result
res_valid  out  1  result valid
res_ready  in  1  downstream accepts
res_a  out  8  echoed operand A
res_b  out  8  echoed operand B
res_gcd  out  8  GCD result
res_err  out  1  result invalid (timeout)
fault  out  1  sticky engine-hang flag

Behaviour:
- Reset (sync, active-high, wins over all else): FIFO empty, state IDLE, req_ready=1, eng_start=0, eng_a=eng_b=0, res_valid=0, res_a=res_b=res_gcd=0, res_err=0, fault=0, watchdog=0. Mid-transaction reset abandons the pair. The engine is not reset by this block.
- FIFO: push when req_valid&req_ready; pop on transition out of IDLE. Simultaneous push and pop on a full FIFO is not allowed (req_ready=0 when full). Pointers wrap modulo DEPTH, with a count register for full/empty.
- FSM states: IDLE, ZERO, ISSUE, WAIT_BUSY, WAIT_DONE, OUTPUT, HALT.
- IDLE: if FIFO non-empty and fault=0, pop head into a/b registers.
  - If a==0 or b==0, go to ZERO.
  - Else go to ISSUE, but only if eng_ready=1. Otherwise stay in IDLE without popping.
- ZERO: res_gcd = a|b (0 when both are 0), res_err=0, go to OUTPUT. No engine activity.
- ISSUE: eng_start=1 for exactly one cycle; eng_a/eng_b = pair. Go to WAIT_BUSY.
- eng_a/eng_b hold stable from ISSUE until the result is captured, because the engine loads operands while READY.
- WAIT_BUSY: wait for eng_ready=0, then go to WAIT_DONE.
- WAIT_DONE: on the first cycle eng_ready=1, capture res_gcd=eng_out and go to OUTPUT. The engine updates its result on the same edge it raises ready.
- Watchdog: clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY/WAIT_DONE. When it reaches TIMEOUT-1, capture res_gcd=0, res_err=1, fault=1, and go to OUTPUT.
- OUTPUT: res_valid=1 with res_a/res_b/res_gcd/res_err stable until res_valid&res_ready. On that handshake, res_valid drops the next cycle. Then go to IDLE, or to HALT if fault=1.
- Back-to-back: a result accepted in cycle N allows the next pop in cycle N+1.
- HALT: no further issues; FIFO still accepts until full. Only rst exits HALT.
- Latency for nonzero operands: ISSUE at 1 cycle after pop, plus engine time, plus 1 cycle capture to res_valid. Zero-operand latency: res_valid 2 cycles after pop.
- Results are delivered strictly in request order.

Test Plan:
- Push (48,18), res_ready=1, model engine → one eng_start pulse, eng_a=48/eng_b=18 held until done; res_gcd=6, res_a=48, res_b=18, res_err=0.
- Push (0,35), then (0,0) → no eng_start; results gcd=35, then gcd=0; each res_valid 2 cycles after pop.
- Push 5 pairs with DEPTH=4 while res_ready=0 → req_ready=0 after 4 accepted (plus 1 in flight). Outputs are in order with correct GCDs (e.g. (12,8)→4, (7,7)→7, (255,1)→1, (100,75)→25, (9,6)→3) once res_ready rises.
- Engine model holds eng_ready=0 forever, TIMEOUT=16 → res_err=1, res_gcd=0, fault=1 16 cycles after WAIT_BUSY entry. Further pushes are accepted but never issued; eng_start stays 0.
- Assert rst during WAIT_DONE → next cycle all outputs are at reset values and the FIFO is empty. A new pair (21,14) after the engine returns ready yields 7.
- eng_ready=0 at pop time (engine busy from a prior user) → driver stays in IDLE with no pop until ready=1, then issues normally.

Source files
------------

// File: rtl/gcd_driver.sv
// Initiator for the 8-bit start/ready GCD engine: buffers operand pairs in a FIFO,
// issues them one at a time, resolves zero operands locally and watches for a hung engine.
module gcd_driver #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       eng_start,
    output logic [7:0] eng_a,
    output logic [7:0] eng_b,
    input  logic       eng_ready,
    input  logic [7:0] eng_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_a,
    output logic [7:0] res_b,
    output logic [7:0] res_gcd,
    output logic       res_err,
    output logic       fault
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_OUTPUT,
        S_HALT
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       a_q, a_d, b_q, b_d, gcd_q, gcd_d;
    logic             err_q, err_d, fault_q, fault_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             push, pop;
    logic [7:0]       head_a, head_b;

    assign req_ready = (count_q != CNT_FULL);
    assign push      = req_valid && req_ready;
    assign head_a    = fifo_mem[rd_ptr_q][15:8];
    assign head_b    = fifo_mem[rd_ptr_q][7:0];

    // NOTE: storage carries no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {req_a, req_b};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
        fault_d = fault_q;
        wdog_d  = wdog_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && !fault_q) begin
                    if (head_a == 8'd0 || head_b == 8'd0) begin
                        pop     = 1'b1;
                        a_d     = head_a;
                        b_d     = head_b;
                        state_d = S_ZERO;
                    end else if (eng_ready) begin
                        pop     = 1'b1;
                        a_d     = head_a;
                        b_d     = head_b;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ZERO: begin
                gcd_d   = a_q | b_q;
                err_d   = 1'b0;
                state_d = S_OUTPUT;
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                wdog_d = wdog_q + WD_W'(1);
                if (wdog_q == WD_LAST) begin
                    gcd_d   = 8'd0;
                    err_d   = 1'b1;
                    fault_d = 1'b1;
                    state_d = S_OUTPUT;
                end else if (!eng_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                wdog_d = wdog_q + WD_W'(1);
                // The engine drives its result on the same edge it raises ready.
                if (eng_ready) begin
                    gcd_d   = eng_out;
                    err_d   = 1'b0;
                    state_d = S_OUTPUT;
                end else if (wdog_q == WD_LAST) begin
                    gcd_d   = 8'd0;
                    err_d   = 1'b1;
                    fault_d = 1'b1;
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (res_ready) begin
                    state_d = fault_q ? S_HALT : S_IDLE;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            gcd_q    <= '0;
            err_q    <= 1'b0;
            fault_q  <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            gcd_q    <= gcd_d;
            err_q    <= err_d;
            fault_q  <= fault_d;
            wdog_q   <= wdog_d;
        end
    end

    // Operands stay on eng_a/eng_b from issue until the result is captured.
    assign eng_start = (state_q == S_ISSUE);
    assign eng_a     = a_q;
    assign eng_b     = b_q;
    assign res_valid = (state_q == S_OUTPUT);
    assign res_a     = a_q;
    assign res_b     = b_q;
    assign res_gcd   = gcd_q;
    assign res_err   = err_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_gcd_driver.sv
// Directed bench for gcd_driver: behavioural GCD engine, expected-result queue
// filled at request time and drained as results are handshaken.
module tb_gcd_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready;
    logic [7:0] req_a, req_b;
    logic       eng_start, eng_ready;
    logic [7:0] eng_a, eng_b, eng_out;
    logic       res_valid, res_ready;
    logic [7:0] res_a, res_b, res_gcd;
    logic       res_err, fault;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic       e;
    } exp_t;
    exp_t sb[$];

    // Engine model controls (written by the stimulus) and observations (written by the model)
    int   eng_lat   = 3;
    bit   eng_hang  = 1'b0;
    int   ext_until = 0;
    int   cyc = 0;
    int   start_pulses = 0;
    int   hold_bad = 0;

    gcd_driver #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .eng_start (eng_start),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_ready (eng_ready),
        .eng_out   (eng_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_a     (res_a),
        .res_b     (res_b),
        .res_gcd   (res_gcd),
        .res_err   (res_err),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x = a;
        logic [7:0] y = b;
        logic [7:0] t;
        while (y != 8'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine: latches on start while ready, busy for eng_lat cycles, then result+ready together.
    initial begin
        bit         busy = 1'b0;
        logic [7:0] la = '0, lb = '0;
        int         cnt = 0;
        eng_ready = 1'b1;
        eng_out   = 8'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (eng_start === 1'b1) start_pulses++;
            if (busy && (eng_a !== la || eng_b !== lb)) hold_bad++;
            if (!busy && eng_start === 1'b1 && eng_ready) begin
                busy = 1'b1;
                la   = eng_a;
                lb   = eng_b;
                cnt  = eng_lat;
            end else if (busy && !eng_hang) begin
                cnt--;
                if (cnt <= 0) begin
                    busy    = 1'b0;
                    eng_out = gcd_ref(la, lb);
                end
            end
            eng_ready = !busy && (cyc >= ext_until);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input bit track, input bit err);
        int n   = 0;
        bit acc = 1'b0;
        exp_t e;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        while (!acc && n < 100) begin
            @(negedge clk);
            if (req_ready) acc = 1'b1;
            step();
            n++;
        end
        req_valid = 1'b0;
        check("push_accept", 32'(acc), 32'd1);
        if (acc && track) begin
            e.a = a;
            e.b = b;
            e.g = err ? 8'd0 : gcd_ref(a, b);
            e.e = err;
            sb.push_back(e);
        end
    endtask

    task automatic wait_valid(input int budget, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < budget) begin
            @(negedge clk);
            lat++;
            if (res_valid) ok = 1'b1;
        end
    endtask

    task automatic check_result(input string tag, output int lat);
        bit   ok;
        exp_t e;
        wait_valid(60, lat, ok);
        check({tag, "_valid"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({tag, "_res_a"},   32'(res_a),   32'(e.a));
                check({tag, "_res_b"},   32'(res_b),   32'(e.b));
                check({tag, "_res_gcd"}, 32'(res_gcd), 32'(e.g));
                check({tag, "_res_err"}, 32'(res_err), 32'(e.e));
            end
            step();
        end
    endtask

    initial begin
        int lat;
        int s0;
        bit ok;

        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_eng_a",     32'(eng_a),     32'd0);
        check("rst_eng_b",     32'(eng_b),     32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_a",     32'(res_a),     32'd0);
        check("rst_res_b",     32'(res_b),     32'd0);
        check("rst_res_gcd",   32'(res_gcd),   32'd0);
        check("rst_res_err",   32'(res_err),   32'd0);
        check("rst_fault",     32'(fault),     32'd0);
        step();
        rst = 1'b0;
        res_ready = 1'b1;
        step();

        // Basic engine transaction
        s0 = start_pulses;
        push_pair(8'd48, 8'd18, 1'b1, 1'b0);
        check_result("t48_18", lat);
        check("t48_18_latency", 32'(lat), 32'd6);
        check("t48_18_starts", 32'(start_pulses - s0), 32'd1);

        // Zero operands resolved locally, two cycles after pop
        s0 = start_pulses;
        push_pair(8'd0, 8'd35, 1'b1, 1'b0);
        check_result("t0_35", lat);
        check("t0_35_latency", 32'(lat), 32'd3);
        push_pair(8'd0, 8'd0, 1'b1, 1'b0);
        check_result("t0_0", lat);
        check("t0_0_latency", 32'(lat), 32'd3);
        check("zero_no_start", 32'(start_pulses - s0), 32'd0);

        // Fill the FIFO behind a stalled output
        res_ready = 1'b0;
        s0 = start_pulses;
        push_pair(8'd12,  8'd8,  1'b1, 1'b0);
        push_pair(8'd7,   8'd7,  1'b1, 1'b0);
        push_pair(8'd255, 8'd1,  1'b1, 1'b0);
        push_pair(8'd100, 8'd75, 1'b1, 1'b0);
        push_pair(8'd9,   8'd6,  1'b1, 1'b0);
        @(negedge clk);
        check("full_req_ready", 32'(req_ready), 32'd0);
        repeat (10) @(negedge clk);
        check("stall_res_valid", 32'(res_valid), 32'd1);
        check("stall_res_gcd",   32'(res_gcd),   32'd4);
        step();
        res_ready = 1'b1;
        check_result("fill0", lat);
        @(negedge clk);
        @(negedge clk);
        check("back_to_back_start", 32'(eng_start), 32'd1);
        check_result("fill1", lat);
        check_result("fill2", lat);
        check_result("fill3", lat);
        check_result("fill4", lat);
        @(negedge clk);
        check("drain_req_ready", 32'(req_ready), 32'd1);
        check("fill_starts", 32'(start_pulses - s0), 32'd5);
        step();

        // Engine busy from another user at pop time
        s0 = start_pulses;
        ext_until = cyc + 6;
        @(negedge clk);
        step();
        push_pair(8'd27, 8'd18, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("busy_no_start", 32'(start_pulses - s0), 32'd0);
        check("busy_no_valid", 32'(res_valid), 32'd0);
        check_result("t27_18", lat);
        check("busy_starts", 32'(start_pulses - s0), 32'd1);
        check("operand_hold", 32'(hold_bad), 32'd0);

        // Reset while waiting on the engine, with a second pair still queued
        eng_lat = 8;
        s0 = start_pulses;
        push_pair(8'd40, 8'd24, 1'b1, 1'b0);
        push_pair(8'd5,  8'd10, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_eng_start", 32'(eng_start), 32'd0);
        check("mid_rst_eng_a",     32'(eng_a),     32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_res_gcd",   32'(res_gcd),   32'd0);
        check("mid_rst_fault",     32'(fault),     32'd0);
        repeat (20) @(negedge clk);
        check("mid_rst_fifo_empty_valid", 32'(res_valid), 32'd0);
        check("mid_rst_fifo_empty_starts", 32'(start_pulses - s0), 32'd1);
        eng_lat = 3;
        step();
        push_pair(8'd21, 8'd14, 1'b1, 1'b0);
        check_result("t21_14", lat);

        // Hung engine trips the watchdog, then the driver halts
        eng_hang = 1'b1;
        push_pair(8'd30, 8'd12, 1'b1, 1'b1);
        check_result("hang", lat);
        check("hang_latency", 32'(lat), 32'd19);
        @(negedge clk);
        check("hang_fault", 32'(fault), 32'd1);
        step();
        s0 = start_pulses;
        push_pair(8'd6, 8'd4, 1'b0, 1'b0);
        push_pair(8'd8, 8'd8, 1'b0, 1'b0);
        push_pair(8'd9, 8'd3, 1'b0, 1'b0);
        push_pair(8'd2, 8'd3, 1'b0, 1'b0);
        @(negedge clk);
        check("halt_full_req_ready", 32'(req_ready), 32'd0);
        wait_valid(10, lat, ok);
        check("halt_no_valid", 32'(ok), 32'd0);
        check("halt_no_start", 32'(start_pulses - s0), 32'd0);
        check("halt_fault_sticky", 32'(fault), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
